// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 responder that emulates a 256-byte 25AA02E48-style EEPROM (READ, WRITE, WREN, WRDI, RDSR).
// Optional feature macro: SPI_EEPROM_RESPONDER_WP_EN (MAC region 0xFA-0xFF becomes read-only).
module spi_eeprom_responder #(
    parameter logic [47:0] MAC_ADDR = 48'hED14334455BB,
    parameter logic [31:0] INIT_IP  = 32'h00000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       si,
    output logic       so,
    output logic       so_oe,
    output logic       wel,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data
);

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_READ, ST_WRITE, ST_STATUS, ST_IGNORE
    } state_t;

    typedef logic [255:0][7:0] mem_t;

    function automatic logic [7:0] init_byte(input logic [7:0] a);
        logic [7:0] b;
        case (a)
            8'h00:   b = INIT_IP[31:24];
            8'h01:   b = INIT_IP[23:16];
            8'h02:   b = INIT_IP[15:8];
            8'h03:   b = INIT_IP[7:0];
            8'hFA:   b = MAC_ADDR[47:40];
            8'hFB:   b = MAC_ADDR[39:32];
            8'hFC:   b = MAC_ADDR[31:24];
            8'hFD:   b = MAC_ADDR[23:16];
            8'hFE:   b = MAC_ADDR[15:8];
            8'hFF:   b = MAC_ADDR[7:0];
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    function automatic mem_t init_image();
        mem_t img;
        for (int i = 0; i < 256; i++) begin
            img[i] = init_byte(i[7:0]);
        end
        return img;
    endfunction

    // Power-up image lives in the declaration so that reset never touches it.
    mem_t mem_r = init_image();

    logic [1:0] sck_sync_r, cs_sync_r, si_sync_r;
    logic       sck_prev_r;
    logic       sck_s, cs_s, si_s, sck_rise_s, sck_fall_s, byte_done_s;
    logic [7:0] rx_byte_s, rd_byte_s, load_byte_s;
    logic       prot_s, mem_we_s;

    state_t     state_r, state_n;
    logic [2:0] bit_cnt_r, bit_cnt_n;
    logic [6:0] shift_r, shift_n;
    logic [6:0] tx_r, tx_n;
    logic [7:0] addr_r, addr_n;
    logic       so_r, so_n, so_oe_r, so_oe_n, wel_r, wel_n;
    logic       commit_en_r, commit_en_n, is_write_r, is_write_n;
    logic       wr_strobe_r, wr_strobe_n;
    logic [7:0] wr_addr_r, wr_addr_n, wr_data_r, wr_data_n;

    // Two-flop synchronizers plus SCK history; left free-running so they track the pins through reset.
    always_ff @(posedge clock) begin
        sck_sync_r <= {sck_sync_r[0], sck};
        cs_sync_r  <= {cs_sync_r[0], cs_n};
        si_sync_r  <= {si_sync_r[0], si};
        sck_prev_r <= sck_sync_r[1];
    end

    assign sck_s       = sck_sync_r[1];
    assign cs_s        = cs_sync_r[1];
    assign si_s        = si_sync_r[1];
    assign sck_rise_s  = sck_s & ~sck_prev_r;
    assign sck_fall_s  = ~sck_s & sck_prev_r;
    assign rx_byte_s   = {shift_r, si_s};
    assign byte_done_s = (bit_cnt_r == 3'd7);

    // Read-data source: store contents, or the fixed MAC when the region is protected.
    always_comb begin
`ifdef SPI_EEPROM_RESPONDER_WP_EN
        prot_s    = (addr_r >= 8'hFA);
        rd_byte_s = prot_s ? init_byte(addr_r) : mem_r[addr_r];
`else
        prot_s    = 1'b0;
        rd_byte_s = mem_r[addr_r];
`endif
        load_byte_s = (state_r == ST_STATUS) ? {6'b0, wel_r, 1'b0} : rd_byte_s;
    end

    // Next-state and datapath decode; a deselect (cs high) overrides any same-sample SCK edge.
    always_comb begin
        state_n     = state_r;
        bit_cnt_n   = bit_cnt_r;
        shift_n     = shift_r;
        tx_n        = tx_r;
        addr_n      = addr_r;
        so_n        = so_r;
        so_oe_n     = so_oe_r;
        wel_n       = wel_r;
        commit_en_n = commit_en_r;
        is_write_n  = is_write_r;
        wr_strobe_n = 1'b0;
        wr_addr_n   = wr_addr_r;
        wr_data_n   = wr_data_r;
        mem_we_s    = 1'b0;
        if (cs_s) begin
            state_n     = ST_IDLE;
            bit_cnt_n   = 3'd0;
            so_n        = 1'b0;
            so_oe_n     = 1'b0;
            commit_en_n = 1'b0;
            is_write_n  = 1'b0;
            wel_n       = is_write_r ? 1'b0 : wel_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_n   = ST_CMD;
                    bit_cnt_n = 3'd0;
                end
                ST_CMD: begin
                    if (sck_rise_s) begin
                        shift_n   = rx_byte_s[6:0];
                        bit_cnt_n = bit_cnt_r + 3'd1;
                        if (byte_done_s) begin
                            case (rx_byte_s)
                                OP_READ:  state_n = ST_ADDR;
                                OP_WRITE: begin
                                    state_n     = ST_ADDR;
                                    is_write_n  = 1'b1;
                                    commit_en_n = wel_r;
                                end
                                OP_RDSR:  state_n = ST_STATUS;
                                OP_WREN:  begin
                                    wel_n   = 1'b1;
                                    state_n = ST_IGNORE;
                                end
                                OP_WRDI:  begin
                                    wel_n   = 1'b0;
                                    state_n = ST_IGNORE;
                                end
                                default:  state_n = ST_IGNORE;
                            endcase
                        end else begin
                            state_n = ST_CMD;
                        end
                    end else begin
                        state_n = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (sck_rise_s) begin
                        shift_n   = rx_byte_s[6:0];
                        bit_cnt_n = bit_cnt_r + 3'd1;
                        if (byte_done_s) begin
                            addr_n  = rx_byte_s;
                            state_n = is_write_r ? ST_WRITE : ST_READ;
                        end else begin
                            state_n = ST_ADDR;
                        end
                    end else begin
                        state_n = ST_ADDR;
                    end
                end
                ST_WRITE: begin
                    if (sck_rise_s) begin
                        shift_n   = rx_byte_s[6:0];
                        bit_cnt_n = bit_cnt_r + 3'd1;
                        if (byte_done_s) begin
                            // Page write: only the low nibble advances.
                            addr_n = {addr_r[7:4], addr_r[3:0] + 4'd1};
                            if (commit_en_r && !prot_s) begin
                                mem_we_s    = 1'b1;
                                wr_strobe_n = 1'b1;
                                wr_addr_n   = addr_r;
                                wr_data_n   = rx_byte_s;
                            end else begin
                                mem_we_s = 1'b0;
                            end
                        end else begin
                            addr_n = addr_r;
                        end
                    end else begin
                        state_n = ST_WRITE;
                    end
                end
                ST_READ, ST_STATUS: begin
                    if (sck_fall_s) begin
                        so_oe_n   = 1'b1;
                        bit_cnt_n = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd0) begin
                            so_n   = load_byte_s[7];
                            tx_n   = load_byte_s[6:0];
                            addr_n = (state_r == ST_READ) ? addr_r + 8'd1 : addr_r;
                        end else begin
                            so_n = tx_r[6];
                            tx_n = {tx_r[5:0], 1'b0};
                        end
                    end else begin
                        so_oe_n = so_oe_r;
                    end
                end
                ST_IGNORE: state_n = ST_IGNORE;
                default:   state_n = ST_IGNORE;
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IGNORE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 7'd0;
            tx_r        <= 7'd0;
            addr_r      <= 8'd0;
            so_r        <= 1'b0;
            so_oe_r     <= 1'b0;
            wel_r       <= 1'b0;
            commit_en_r <= 1'b0;
            is_write_r  <= 1'b0;
            wr_strobe_r <= 1'b0;
            wr_addr_r   <= 8'd0;
            wr_data_r   <= 8'd0;
        end else begin
            state_r     <= state_n;
            bit_cnt_r   <= bit_cnt_n;
            shift_r     <= shift_n;
            tx_r        <= tx_n;
            addr_r      <= addr_n;
            so_r        <= so_n;
            so_oe_r     <= so_oe_n;
            wel_r       <= wel_n;
            commit_en_r <= commit_en_n;
            is_write_r  <= is_write_n;
            wr_strobe_r <= wr_strobe_n;
            wr_addr_r   <= wr_addr_n;
            wr_data_r   <= wr_data_n;
        end
    end

    // Byte store write port.
    always_ff @(posedge clock) begin
        if (mem_we_s && !reset) begin
            mem_r[addr_r] <= rx_byte_s;
        end
    end

    assign so        = so_r;
    assign so_oe     = so_oe_r;
    assign wel       = wel_r;
    assign wr_strobe = wr_strobe_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Bench for spi_eeprom_responder: directed table, hand-written corner sequences and random
// transactions checked against a transaction-level EEPROM model.
module tb_spi_eeprom_responder;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;
`ifdef SPI_EEPROM_RESPONDER_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset, sck, cs_n, si;
    logic       so, so_oe, wel, wr_strobe;
    logic [7:0] wr_addr, wr_data;

    int n_pass  = 0;
    int n_total = 0;

    spi_eeprom_responder dut (
        .clock(clock), .reset(reset), .sck(sck), .cs_n(cs_n), .si(si),
        .so(so), .so_oe(so_oe), .wel(wel), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clock = ~clock;

    initial begin
        #800000;
        $display("FAIL watchdog: got no summary before time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Every clock the strobe is high is recorded, so a stretched pulse shows up as an extra entry.
    logic [15:0] got_q[$];
    always @(negedge clock) begin
        if (wr_strobe === 1'b1) got_q.push_back({wr_addr, wr_data});
    end

    // ---------------- reference model (transaction level) ----------------
    logic [7:0]  ref_mem [256];
    logic        ref_wel;
    logic [15:0] exp_q[$];
    logic [7:0]  exp_rx [8];
    logic [7:0]  tx_buf [8];
    logic [7:0]  rx_buf [8];

    function automatic logic [7:0] ref_rd(input logic [7:0] a);
        logic [47:0] mac;
        mac = 48'hED14334455BB;
        if (WP && a >= 8'hFA) return mac[8*(255 - int'(a)) +: 8];
        return ref_mem[a];
    endfunction

    task automatic model_init();
        logic [47:0] mac;
        mac = 48'hED14334455BB;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'hFF;
        for (int i = 0; i < 4; i++) ref_mem[i] = 8'h00;
        for (int k = 0; k < 6; k++) ref_mem[250 + k] = mac[47 - 8*k -: 8];
        ref_wel = 1'b0;
    endtask

    task automatic model_txn(input logic [7:0] op, input logic [7:0] addr, input int n);
        int a;
        exp_q.delete();
        case (op)
            OP_WREN: ref_wel = 1'b1;
            OP_WRDI: ref_wel = 1'b0;
            OP_RDSR: for (int i = 0; i < n; i++) exp_rx[i] = ref_wel ? 8'h02 : 8'h00;
            OP_READ: for (int i = 0; i < n; i++) exp_rx[i] = ref_rd(8'((int'(addr) + i) % 256));
            OP_WRITE: begin
                for (int i = 0; i < n; i++) begin
                    a = (int'(addr) / 16) * 16 + (int'(addr) + i) % 16;
                    if (ref_wel && !(WP && a >= 250)) begin
                        ref_mem[a] = tx_buf[i];
                        exp_q.push_back({8'(a), tx_buf[i]});
                    end
                end
                ref_wel = 1'b0;
            end
            default: ;
        endcase
    endtask

    // ---------------- SPI initiator ----------------
    task automatic xfer(input logic [7:0] b, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            si = b[i];
            repeat (8) @(negedge clock);
            r[i] = so;
            sck = 1'b1;
            repeat (8) @(negedge clock);
            sck = 1'b0;
        end
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [7:0] addr, input int n);
        logic [7:0] dummy;
        got_q.delete();
        @(negedge clock);
        cs_n = 1'b0;
        xfer(op, dummy);
        if (op == OP_READ || op == OP_WRITE) xfer(addr, dummy);
        for (int i = 0; i < n; i++) xfer((op == OP_WRITE) ? tx_buf[i] : 8'h00, rx_buf[i]);
        repeat (8) @(negedge clock);
        if ((op == OP_READ || op == OP_RDSR) && n > 0) check("so_oe_during_data", so_oe, 1);
        cs_n = 1'b1;
        repeat (16) @(negedge clock);
        check("so_oe_after_cs", so_oe, 0);
    endtask

    task automatic compare_model(input string tag, input logic [7:0] op, input int n);
        if (op == OP_READ || op == OP_RDSR)
            for (int i = 0; i < n; i++) check($sformatf("%s_rx%0d", tag, i), rx_buf[i], exp_rx[i]);
        check($sformatf("%s_strobe_cnt", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_strobe%0d", tag, i), got_q[i], exp_q[i]);
        check($sformatf("%s_wel", tag), wel, ref_wel);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0]  op;
        logic [7:0]  addr;
        int          n;
        logic [63:0] d;      // data bytes, left-aligned
        logic [63:0] exp;    // expected read bytes, left-aligned
        int          ns;     // expected strobe count
        logic [31:0] saddr;  // expected strobe addresses, left-aligned
        logic        wel;
    } vec_t;

    function automatic vec_t mkv(logic [7:0] op, logic [7:0] addr, int n, logic [63:0] d,
                                 logic [63:0] exp, int ns, logic [31:0] saddr, logic w);
        vec_t v;
        v.op = op; v.addr = addr; v.n = n; v.d = d; v.exp = exp;
        v.ns = ns; v.saddr = saddr; v.wel = w;
        return v;
    endfunction

    vec_t vecs [18];

    initial begin
        logic [7:0] r;
        logic [7:0] op, addr;
        int n, sel;

        vecs[0]  = mkv(OP_READ,  8'hFA, 8, 64'h0, 64'hED14334455BB0000, 0, 32'h0, 1'b0);
        vecs[1]  = mkv(OP_RDSR,  8'h00, 1, 64'h0, 64'h0, 0, 32'h0, 1'b0);
        vecs[2]  = mkv(OP_WRITE, 8'h00, 4, 64'hC0A8016400000000, 64'h0, 0, 32'h0, 1'b0);
        vecs[3]  = mkv(OP_READ,  8'h00, 4, 64'h0, 64'h0, 0, 32'h0, 1'b0);
        vecs[4]  = mkv(OP_WREN,  8'h00, 0, 64'h0, 64'h0, 0, 32'h0, 1'b1);
        vecs[5]  = mkv(OP_RDSR,  8'h00, 2, 64'h0, 64'h0202000000000000, 0, 32'h0, 1'b1);
        vecs[6]  = mkv(OP_WRITE, 8'h00, 4, 64'hC0A8016400000000, 64'h0, 4, 32'h00010203, 1'b0);
        vecs[7]  = mkv(OP_READ,  8'h00, 4, 64'h0, 64'hC0A8016400000000, 0, 32'h0, 1'b0);
        vecs[8]  = mkv(OP_WREN,  8'h00, 0, 64'h0, 64'h0, 0, 32'h0, 1'b1);
        vecs[9]  = mkv(OP_WRDI,  8'h00, 0, 64'h0, 64'h0, 0, 32'h0, 1'b0);
        vecs[10] = mkv(OP_RDSR,  8'h00, 1, 64'h0, 64'h0, 0, 32'h0, 1'b0);
        vecs[11] = mkv(OP_WREN,  8'h00, 0, 64'h0, 64'h0, 0, 32'h0, 1'b1);
        vecs[12] = mkv(OP_WRITE, 8'h0E, 3, 64'hAABBCC0000000000, 64'h0, 3, 32'h0E0F0000, 1'b0);
        vecs[13] = mkv(OP_READ,  8'h0E, 3, 64'h0, 64'hAABBFF0000000000, 0, 32'h0, 1'b0);
        vecs[14] = mkv(OP_READ,  8'h00, 2, 64'h0, 64'hCCA8000000000000, 0, 32'h0, 1'b0);
        vecs[15] = mkv(OP_WREN,  8'h00, 0, 64'h0, 64'h0, 0, 32'h0, 1'b1);
        vecs[16] = mkv(OP_WRITE, 8'hFC, 1, 64'h1100000000000000, 64'h0, WP ? 0 : 1, 32'hFC000000, 1'b0);
        vecs[17] = mkv(OP_READ,  8'hFC, 1, 64'h0, WP ? 64'h3300000000000000 : 64'h1100000000000000,
                       0, 32'h0, 1'b0);

        model_init();
        reset = 1'b1; sck = 1'b0; cs_n = 1'b1; si = 1'b0;
        repeat (6) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_so", so, 0);
        check("rst_so_oe", so_oe, 0);
        check("rst_wel", wel, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        repeat (4) @(negedge clock);

        for (int v = 0; v < 18; v++) begin
            for (int i = 0; i < 8; i++) tx_buf[i] = vecs[v].d[63 - 8*i -: 8];
            model_txn(vecs[v].op, vecs[v].addr, vecs[v].n);
            run_txn(vecs[v].op, vecs[v].addr, vecs[v].n);
            if (vecs[v].op == OP_READ || vecs[v].op == OP_RDSR)
                for (int i = 0; i < vecs[v].n; i++)
                    check($sformatf("v%0d_rx%0d", v, i), rx_buf[i], vecs[v].exp[63 - 8*i -: 8]);
            check($sformatf("v%0d_strobe_cnt", v), got_q.size(), vecs[v].ns);
            for (int i = 0; i < vecs[v].ns && i < got_q.size(); i++)
                check($sformatf("v%0d_strobe%0d", v, i), got_q[i],
                      {vecs[v].saddr[31 - 8*i -: 8], vecs[v].d[63 - 8*i -: 8]});
            check($sformatf("v%0d_wel", v), wel, vecs[v].wel);
        end

        // cs_n rise on the same sample as the 8th data-bit rise: byte dropped, wel still cleared.
        model_txn(OP_WREN, 8'h00, 0);
        run_txn(OP_WREN, 8'h00, 0);
        check("race_wren", wel, 1);
        got_q.delete();
        @(negedge clock);
        cs_n = 1'b0;
        xfer(OP_WRITE, r);
        xfer(8'h20, r);
        for (int i = 7; i >= 1; i--) begin
            si = i[0];
            repeat (8) @(negedge clock);
            sck = 1'b1;
            repeat (8) @(negedge clock);
            sck = 1'b0;
        end
        si = 1'b1;
        repeat (8) @(negedge clock);
        sck = 1'b1;
        cs_n = 1'b1;
        repeat (16) @(negedge clock);
        sck = 1'b0;
        repeat (16) @(negedge clock);
        ref_wel = 1'b0;
        check("race_no_strobe", got_q.size(), 0);
        check("race_wel_cleared", wel, 0);
        model_txn(OP_READ, 8'h20, 1);
        run_txn(OP_READ, 8'h20, 1);
        check("race_mem_unchanged", rx_buf[0], 8'hFF);

        // Reset in the middle of a READ with cs_n held low.
        @(negedge clock);
        cs_n = 1'b0;
        xfer(OP_READ, r);
        xfer(8'h00, r);
        xfer(8'h00, r);
        check("midrst_first_byte", r, 8'hCC);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_so_oe", so_oe, 0);
        check("midrst_so", so, 0);
        got_q.delete();
        xfer(OP_WREN, r);
        xfer(OP_READ, r);
        check("midrst_ignored_so_oe", so_oe, 0);
        check("midrst_ignored_wel", wel, 0);
        cs_n = 1'b1;
        repeat (16) @(negedge clock);
        model_txn(OP_READ, 8'hFA, 1);
        run_txn(OP_READ, 8'hFA, 1);
        check("midrst_mac_read", rx_buf[0], 8'hED);
        check("midrst_no_strobe", got_q.size(), 0);

        // Randomized transactions against the model.
        for (int t = 0; t < 20; t++) begin
            sel  = $urandom_range(0, 9);
            addr = 8'($urandom);
            case (sel)
                0, 1:    op = OP_WREN;
                2:       op = OP_WRDI;
                3:       op = OP_RDSR;
                4, 5:    op = OP_READ;
                9:       op = 8'h9F;
                default: op = OP_WRITE;
            endcase
            if (op == OP_READ || op == OP_WRITE) n = $urandom_range(1, 6);
            else if (op == OP_RDSR) n = $urandom_range(1, 2);
            else n = 0;
            for (int i = 0; i < 8; i++) tx_buf[i] = 8'($urandom);
            model_txn(op, addr, n);
            run_txn(op, addr, n);
            compare_model($sformatf("rnd%0d_op%02h", t, op), op, n);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_eeprom_responder.md
# spi_eeprom_responder

- Responder (slave) end of the four-wire SPI EEPROM link: emulates a 256-byte 25AA02E48-style serial EEPROM inside the FPGA.
- Answers READ, WREN, WRDI, WRITE and RDSR from the EEPROM initiator, so the MAC/IP boot read and the static-IP write work on boards without the physical part.
- Sits between the initiator's SCK/SI/SO/CS pins and an internal byte store.
- Also exposes a write-event strobe so host logic can observe committed bytes.

## Interface
Parameters:
- MAC_ADDR, 48'hED14334455BB: factory MAC presented at 0xFA–0xFF, MSB first.
- INIT_IP, 32'h00000000: power-up contents of 0x00–0x03, MSB at 0x00.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock; must be ≥8× SCK frequency.
- reset  in  1  synchronous, active-high.
- sck  in  1  SPI clock from initiator, mode 0.
- cs_n  in  1  chip select, active low.
- si  in  1  serial data from initiator.
- so  out  1  serial data to initiator.
- so_oe  out  1  output enable for so; high only while shifting read/status data.
- wel  out  1  write-enable latch.
- wr_strobe  out  1  one-clock pulse per committed write byte.
- wr_addr  out  8  address of committed byte.
- wr_data  out  8  committed byte.

## Operation
- **Input sampling:** sck, cs_n and si each pass through a 2-flop synchronizer in clock. Edges are detected on the synchronized copies.
- **SCK edges:** si is sampled on each sck rise while cs_n is low; so changes only on sck fall.
- **States:**
  - IDLE: cs_n high.
  - CMD: shifting opcode.
  - ADDR: shifting address.
  - READ, WRITE, STATUS: data phases.
  - IGNORE: unknown opcode, or selected at reset release.
- **Opcode decode** after 8 bits:
  - 0x03 → ADDR then READ.
  - 0x02 → ADDR then WRITE.
  - 0x05 → STATUS.
  - 0x06 sets wel; 0x04 clears wel; both then go to IGNORE.
  - Any other opcode → IGNORE.
- **READ:**
  - Byte at the address is shifted out MSB first.
  - Address auto-increments after each byte, 8-bit wrap 0xFF→0x00.
  - Continues until cs_n rises.
- **STATUS:** returns {6'b0, wel, 1'b0} repeatedly (WIP is always 0).
- **WRITE:**
  - Each complete received byte commits to address, then address increments within the 16-byte page: low nibble wraps, high nibble unchanged.
  - A commit pulses wr_strobe with wr_addr/wr_data.
  - Commits occur only if wel was 1 at opcode decode; otherwise bytes are discarded.
- **cs_n rise:** any state returns to IDLE and so_oe drops. A partial byte is discarded. If the transaction was a WRITE opcode, wel clears.
- **Storage:**
  - 0x00–0xF9: RAM, initialized 0xFF except 0x00–0x03 = INIT_IP.
  - 0xFA–0xFF: MAC region (see Configuration).
  - reset does not alter stored contents.

## Timing
- Reset values: so=0, so_oe=0, wel=0, wr_strobe=0, wr_addr=0, wr_data=0, state=IGNORE.
- Leaving reset with cs_n low: stay in IGNORE until cs_n rises, so a mid-frame reset never misparses.
- cs_n fall → CMD within 3 clocks of the pin edge.
- so_oe asserts and the first data bit (MSB) is driven on the sck fall after the 8th address bit (READ) or 8th opcode bit (RDSR). That bit is valid before the next sck rise. The memory read must complete within that half-period, ≤4 clocks after sck-rise detection.
- Each subsequent bit updates ≤3 clocks after the pin-level sck fall.
- wr_strobe is high for exactly 1 clock, ≤3 clocks after the 8th data-bit sck rise is detected.
- A cs_n high pulse of one SCK period (WREN→WRITE gap) must be recognized. Guaranteed by the ≥8× ratio.
- Simultaneous cs_n rise and 8th-bit sck rise on the same synchronized sample: cs_n wins, the byte is discarded.

## Configuration
- Macro: SPI_EEPROM_RESPONDER_WP_EN.
- **Defined:**
  - 0xFA–0xFF are read-only and always return MAC_ADDR bytes.
  - WRITE bytes landing there are dropped: no wr_strobe, address still increments.
- **Undefined:**
  - 0xFA–0xFF are ordinary RAM, initialized from MAC_ADDR.
  - Writes there commit and strobe like any other address.

## Test plan
- READ 0x03,0xFA then 80 clocks → so yields ED 14 33 44 55 BB, then bytes 0x00–0x03 (00 00 00 00) after the wrap.
- WREN, 1-SCK cs_n high, WRITE 0x02,0x00,C0 A8 01 64, cs_n high → 4 wr_strobe pulses (addr 00..03); wel=0 after; READ 0x00 returns C0 A8 01 64.
- WRITE without a preceding WREN → no wr_strobe, memory unchanged; RDSR returns 0x00. After WREN, RDSR returns 0x02.
- WREN then WRITE 0x0E with 3 bytes → commits at 0x0E, 0x0F, 0x00 (page wrap).
- WP_EN defined: WREN, WRITE 0xFC with 0x11 → no strobe, READ 0xFC returns 0x33. WP_EN undefined: strobe and readback 0x11.
- reset asserted mid-READ with cs_n held low → so_oe=0, ignores sck until cs_n rises; the next READ 0xFA returns ED.
